// File: rtl/risp_synapse.sv
// -----------------------------------------------------------------------------
// risp_synapse
//
// Transmit side of the neuron charge interface for one network edge. A fire
// from the presynaptic neuron is held in flight for DELAY enabled time steps
// and then presented as a signed WEIGHT on the postsynaptic neuron's charge
// input for exactly one enabled step.
//
// Two storage modes, chosen by MAX_INFLIGHT:
//   0     : DELAY-bit shift register, one bit per time step. Any number of
//           spikes may be in flight.
//   N > 0 : N-entry FIFO of due-timestamps compared against a free-running
//           step counter. Suited to long delays with sparse spikes. When the
//           FIFO is full and nothing pops, the spike is dropped and the sticky
//           overflow flag is raised.
//
// Parameters:
//   WEIGHT        signed charge per spike; must fit in CHARGE_WIDTH signed bits
//   DELAY         enabled steps from fire to charge, >= 1
//   CHARGE_WIDTH  width of the charge output
//   MAX_INFLIGHT  0 = shift mode, N > 0 = N-entry timestamp FIFO
//
// Ports:
//   clk          clock
//   arstn        asynchronous active-low reset
//   en           time-step enable; no state changes while en = 0
//   clr          synchronous clear of all in-flight spikes (qualified by en);
//                the fire sampled on the same edge is discarded
//   fire         presynaptic fire, sampled on enabled edges
//   charge       WEIGHT when a spike is due this step, else 0 (combinational)
//   overflow     sticky: a spike was dropped because the FIFO was full
//   spike_count  (only with RISP_SYNAPSE_SPIKE_COUNT_EN) saturating 16-bit
//                count of delivered spikes
//
// Optional feature macro: RISP_SYNAPSE_SPIKE_COUNT_EN
// -----------------------------------------------------------------------------
module risp_synapse #(
  parameter int WEIGHT       = 1,
  parameter int DELAY        = 1,
  parameter int CHARGE_WIDTH = 8,
  parameter int MAX_INFLIGHT = 0
) (
  input  logic                           clk,
  input  logic                           arstn,
  input  logic                           en,
  input  logic                           clr,
  input  logic                           fire,
  output logic signed [CHARGE_WIDTH-1:0] charge,
  output logic                           overflow
`ifdef RISP_SYNAPSE_SPIKE_COUNT_EN
  ,
  output logic [15:0]                    spike_count
`endif
);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  localparam longint W_MAX = (longint'(1) << (CHARGE_WIDTH - 1)) - 1;
  localparam longint W_MIN = -W_MAX - 1;

  if (DELAY < 1) begin : g_bad_delay
    $error("risp_synapse: DELAY must be >= 1");
  end

  if ((longint'(WEIGHT) > W_MAX) || (longint'(WEIGHT) < W_MIN)) begin : g_bad_weight
    $error("risp_synapse: WEIGHT does not fit in CHARGE_WIDTH signed bits");
  end

  if (MAX_INFLIGHT < 0) begin : g_bad_inflight
    $error("risp_synapse: MAX_INFLIGHT must be >= 0");
  end

  localparam logic signed [CHARGE_WIDTH-1:0] WGT = CHARGE_WIDTH'(WEIGHT);

  // Asserted while the spike at the output of the delay line is due.
  logic w_due;

  // Charge is a pure function of stored state, so it holds across en = 0.
  assign charge = w_due ? WGT : '0;

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  if (MAX_INFLIGHT == 0) begin : g_shift
    // Guard keeps the vector legal while the DELAY check reports the error.
    localparam int SW = (DELAY < 1) ? 1 : DELAY;

    // Bit i set means a spike fired i+1 enabled edges ago.
    logic [SW-1:0] r_stage;

    // NOTE: clocked state is always assigned with <= so every register
    // samples the pre-edge values of its neighbours; = here would let a spike
    // ripple through several stages in one edge.
    always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
        r_stage <= '0;
      end else if (en) begin
        if (clr) begin
          r_stage <= '0;
        end else begin
          r_stage <= (r_stage << 1) | SW'(fire);
        end
      end
    end

    assign w_due    = r_stage[SW-1];
    assign overflow = 1'b0;

  end else begin : g_fifo
    localparam int N  = MAX_INFLIGHT;
    localparam int TW = $clog2(DELAY + 1);          // DELAY < 2**TW: no aliasing
    localparam int PW = (N > 1) ? $clog2(N) : 1;    // head/tail pointer width
    localparam int CW = $clog2(N + 1);              // occupancy count width

    localparam logic [TW-1:0] DELAY_T = TW'(DELAY);
    localparam logic [PW-1:0] LAST_P  = PW'(N - 1);
    localparam logic [CW-1:0] FULL_C  = CW'(N);

    logic [TW-1:0] r_now;
    logic [TW-1:0] r_due_mem [N];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic          r_overflow;

    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;

    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
      return (p == LAST_P) ? '0 : p + PW'(1);
    endfunction

    // Pushes are in time order, one per step, so only the head can be due.
    assign w_due  = (r_count != '0) && (r_due_mem[r_head] == r_now);
    assign w_full = (r_count == FULL_C);

    // NOTE: every signal written in an always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
      w_pop  = 1'b0;
      w_push = 1'b0;
      w_drop = 1'b0;
      if (en && !clr) begin
        w_pop  = w_due;
        // A same-edge pop frees the slot before the push needs it.
        w_push = fire && (!w_full || w_due);
        w_drop = fire && w_full && !w_due;
      end
    end

    always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
        r_now      <= '0;
        r_head     <= '0;
        r_tail     <= '0;
        r_count    <= '0;
        r_overflow <= 1'b0;
      end else if (en) begin
        if (clr) begin
          r_now      <= '0;
          r_head     <= '0;
          r_tail     <= '0;
          r_count    <= '0;
          r_overflow <= 1'b0;
        end else begin
          r_now <= r_now + TW'(1);
          if (w_pop) begin
            r_head <= f_inc(r_head);
          end
          if (w_push) begin
            r_tail <= f_inc(r_tail);
          end
          if (w_push && !w_pop) begin
            r_count <= r_count + CW'(1);
          end else if (w_pop && !w_push) begin
            r_count <= r_count - CW'(1);
          end
          if (w_drop) begin
            r_overflow <= 1'b1;
          end
        end
      end
    end

    // NOTE: the timestamp array has no reset; an entry is only read once the
    // occupancy count covers it, and the count itself is reset.
    always_ff @(posedge clk) begin
      if (w_push) begin
        r_due_mem[r_tail] <= r_now + DELAY_T;
      end
    end

    assign overflow = r_overflow;
  end

  // ---------------------------------------------------------------------------
  // Optional delivered-spike counter
  // ---------------------------------------------------------------------------
`ifdef RISP_SYNAPSE_SPIKE_COUNT_EN
  logic [15:0] r_spike_count;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_spike_count <= '0;
    end else if (en) begin
      if (clr) begin
        r_spike_count <= '0;
      end else if ((charge != '0) && (r_spike_count != 16'hFFFF)) begin
        r_spike_count <= r_spike_count + 16'd1;
      end
    end
  end

  assign spike_count = r_spike_count;
`endif

endmodule
